// File: rtl/seq_mult.sv
// Shift-add sequential multiplier (unsigned or two's complement), one ADD and one SHIFT cycle per bit.
// Optional Abort input enabled by defining SEQ_MULT_ABORT_EN.
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               St,
    input  logic               Signed,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef SEQ_MULT_ABORT_EN
    input  logic               Abort,
`endif
    output logic               Idle,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] P
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    logic               abort_req;
    logic [2*WIDTH:0]   shifted;
    logic [2*WIDTH-1:0] prod_mag;

`ifdef SEQ_MULT_ABORT_EN
    assign abort_req = Abort;
`else
    assign abort_req = 1'b0;
`endif

    // Magnitudes stay WIDTH-bit unsigned so the most-negative operand is exact.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? -x : x;
    endfunction

    assign shifted  = {acc_q, mq_q} >> 1;
    assign prod_mag = shifted[2*WIDTH-1:0];

    // NOTE: every register is reset because P and the handshake must be defined right after Reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            mq_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            p_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            state_q <= state_d;
            mcand_q <= mcand_d;
            mq_q    <= mq_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
        state_d = state_q;
        mcand_d = mcand_q;
        mq_d    = mq_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        p_d     = p_q;
        Idle    = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                Idle = 1'b1;
                if (St) begin
                    mcand_d = magnitude(A, Signed);
                    mq_d    = magnitude(B, Signed);
                    acc_d   = '0;
                    cnt_d   = '0;
                    neg_d   = Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                Busy = 1'b1;
                if (mq_q[0]) begin
                    acc_d = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, mcand_q};
                end
                state_d = abort_req ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                Busy  = 1'b1;
                acc_d = shifted[2*WIDTH:WIDTH];
                mq_d  = shifted[WIDTH-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (abort_req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    p_d     = neg_q ? -prod_mag : prod_mag;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                Done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign P = p_q;

endmodule
